// File: rtl/btn_debounce.sv
// Push-button conditioner: polarity fix, 2-flop synchroniser, per-channel debounce, press/release
// strobes. Define BTN_DEBOUNCE_REPEAT_EN to add hold-to-repeat press strobes.
module btn_debounce #(
    parameter int unsigned      N_BTN           = 7,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter int unsigned      CTR_WIDTH       = 18,
    parameter logic [N_BTN-1:0] INVERT_MASK     = 7'b0000001,
    parameter int unsigned      REPEAT_DELAY    = 12500000,
    parameter int unsigned      REPEAT_PERIOD   = 2500000,
    parameter int unsigned      RPT_WIDTH       = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    localparam logic [CTR_WIDTH-1:0] CntLast = CTR_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY ||
        (RPT_WIDTH < 32 && REPEAT_DELAY >= (32'd1 << RPT_WIDTH))) begin : g_bad_cfg
        $error("btn_debounce: invalid parameter set");
    end

    logic [N_BTN-1:0]     sync1_q, sync2_q;
    logic [N_BTN-1:0]     level_q, level_d;
    logic [N_BTN-1:0]     press_q, press_d;
    logic [N_BTN-1:0]     release_q, release_d;
    logic [CTR_WIDTH-1:0] cnt_q [N_BTN];
    logic [CTR_WIDTH-1:0] cnt_d [N_BTN];

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam logic [RPT_WIDTH-1:0] RptHit    = RPT_WIDTH'(REPEAT_DELAY);
    // After a repeat, rewinding here makes the counter hit RptHit again REPEAT_PERIOD cycles later.
    localparam logic [RPT_WIDTH-1:0] RptRewind = RPT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [RPT_WIDTH-1:0] rc_q [N_BTN];
    logic [RPT_WIDTH-1:0] rc_d [N_BTN];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                rc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                rc_q[i] <= rc_d[i];
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn ^ INVERT_MASK;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
`ifdef BTN_DEBOUNCE_REPEAT_EN
            // Only a steadily held level counts, so a repeat can never share a cycle with release.
            rc_d[i] = '0;
            if (level_d[i] && !press_d[i]) begin
                rc_d[i] = (rc_q[i] == RptHit) ? RptRewind : rc_q[i] + 1'b1;
                if (rc_d[i] == RptHit) begin
                    press_d[i] = 1'b1;
                end
            end
`endif
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the ULX3S push-buttons, clocked from the 25 MHz board clock.
- Synchronises the raw `btn[6:0]` pad inputs, normalises their polarity and debounces each one independently.
- Emits clean levels plus single-cycle press/release strobes.
- Consumers (LED/status logic, menus, counters) use these outputs instead of raw `btn`.

Parameters:
- N_BTN, 7 — number of button channels.
- DEBOUNCE_CYCLES, 250000 — consecutive stable cycles required to accept a new level (10 ms at 25 MHz); must be ≥ 2.
- CTR_WIDTH, 18 — debounce counter width; 2^CTR_WIDTH must exceed DEBOUNCE_CYCLES.
- INVERT_MASK, 7'b0000001 — bit i set means raw `btn[i]` is active-low (ULX3S PWR button); inverted before synchronisation.
- REPEAT_DELAY, 12500000 — hold time before the first auto-repeat pulse (0.5 s); used only with the optional feature.
- REPEAT_PERIOD, 2500000 — interval between auto-repeat pulses (0.1 s); used only with the optional feature.
- RPT_WIDTH, 24 — auto-repeat counter width; must hold REPEAT_DELAY.

Ports:
- i_clk  input  1  system clock (clk_25mhz)
- i_reset  input  1  synchronous, active-high reset
- btn  input  N_BTN  raw asynchronous button pads
- o_level  output  N_BTN  debounced level, 1 = pressed
- o_press  output  N_BTN  one-cycle strobe on an accepted press (plus auto-repeats when enabled)
- o_release  output  N_BTN  one-cycle strobe on an accepted release

Behaviour:
- Clocking and reset:
  - One clock domain: `i_clk`.
  - Reset is synchronous and active-high on `i_reset`.
  - While `i_reset` is high at a rising edge, every register clears: sync flops, counters, `o_level`, `o_press`, `o_release` = 0.
  - Reset asserted mid-count discards the partial count.
  - No strobe may appear in the first cycle after reset deasserts.
- Front end:
  - `x[i] = btn[i] XOR INVERT_MASK[i]`.
  - `x` passes through a 2-flop synchroniser, giving `s[i]` with 2 cycles of latency.
- Per-channel debounce (all channels independent, identical logic):
  - Each channel holds a state `lvl` (drives `o_level[i]`) and a counter `cnt` of CTR_WIDTH bits.
  - If `s == lvl`: `cnt <= 0`.
  - If `s != lvl` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s`, `cnt <= 0`, and a strobe fires in the same registered cycle.
    - `o_press[i]` fires if the new `lvl` is 1; `o_release[i]` fires if it is 0.
- Latency:
  - A clean input step reaches `o_level` exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
  - Strobes align with the `o_level` transition cycle.
- Glitch rejection:
  - Any excursion of `s` shorter than DEBOUNCE_CYCLES cycles returns `cnt` to 0.
  - No change to `o_level` and no strobe.
  - Counting restarts from 0 on every bounce, so the level is accepted only after DEBOUNCE_CYCLES uninterrupted cycles.
- Strobe rules:
  - `o_press` and `o_release` are never high together on the same channel.
  - Each is high for exactly one cycle per event; 0 otherwise.
  - Simultaneous events on different channels are independent and may strobe in the same cycle.
- Power-up:
  - A button held through reset produces `o_level = 1` and one `o_press` DEBOUNCE_CYCLES+2 cycles after reset release.
- Counter saturation: `cnt` never wraps, because it is bounded by DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Defined:
  - Each channel adds a repeat counter `rc` (RPT_WIDTH bits), cleared on reset, on an accepted press, and whenever `lvl = 0`.
  - While `lvl = 1`, `rc` counts every cycle.
  - First repeat: `o_press` pulses one cycle when `rc` reaches REPEAT_DELAY.
  - Subsequent repeats: `o_press` pulses every REPEAT_PERIOD cycles after that while held.
  - Release stops repeats immediately; no repeat strobe may coincide with `o_release`.
- Undefined: no repeat logic is synthesised, REPEAT_* parameters are ignored, and exactly one `o_press` occurs per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, INVERT_MASK=7'b0000001):
- Reset, all `btn=0` except `btn[0]=1` (idle, active-low) held for 20 cycles → `o_level=0`; no strobes on any channel.
- `btn[1]` 0→1 clean step → `o_level[1]` rises and `o_press[1]` pulses one cycle exactly 6 edges later; `btn[1]` 1→0 → `o_release[1]` pulses after 6 edges.
- `btn[2]` bounces 1,0,1,0,1 (1 cycle each), then holds 1 → no strobe during the bounce; one `o_press[2]` 6 cycles after the last 0→1.
- `btn[0]` driven 0 (pressed) and `btn[3]` 0→1 in the same cycle → `o_press[0]` and `o_press[3]` in the same cycle; `o_level=7'b0001001`.
- `i_reset` pulsed with `cnt[1]=2` mid-debounce while `btn[1]` stays 1 → all outputs 0 during reset; `o_press[1]` 6 cycles after reset release.
- BTN_DEBOUNCE_REPEAT_EN defined, `btn[4]` held → initial `o_press[4]`, then repeats 10 cycles later and every 3 cycles after; release → `o_release[4]` only, with no further `o_press[4]`.
